// File: rtl/mem_write_demux.sv
// Purpose : routes one accepted CPU write to SRAM, the hex-display register or the LED register.
// Latency : done pulses 1 cycle after accept for I/O writes, SRAM_WAIT+1 cycles after accept for SRAM.
// Backpr. : req_ready is high only in IDLE; a held request is taken on the first IDLE edge.
//
// Ports:
//   Clk, Reset_n             clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready      request handshake; req_addr/req_data sampled only at accept
//   done                     one-cycle completion pulse
//   sram_we/addr/wdata       SRAM strobe and latched address/data
//   hex_out, led_out         memory-mapped I/O registers
module mem_write_demux #(
    parameter int                 DATA_W    = 16,
    parameter int                 SRAM_WAIT = 2,
    parameter logic [DATA_W-1:0]  HEX_ADDR  = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0]  LED_ADDR  = {{(DATA_W-1){1'b1}}, 1'b0}
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              done,
    output logic              sram_we,
    output logic [DATA_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic [DATA_W-1:0] hex_out,
    output logic [DATA_W-1:0] led_out
);

    localparam int CNT_W = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SRAM_WR = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hex_q, hex_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic [DATA_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hex_d        = hex_q;
        led_d        = led_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;

        case (state_q)
            ST_IDLE: begin
                // req_ready is implied by being in IDLE, so valid alone is the accept
                if (req_valid) begin
                    if (req_addr == HEX_ADDR) begin
                        hex_d   = req_data;
                        state_d = ST_DONE;
                    end else if (req_addr == LED_ADDR) begin
                        led_d   = req_data;
                        state_d = ST_DONE;
                    end else begin
                        sram_addr_d  = req_addr;
                        sram_wdata_d = req_data;
                        // cnt counts down from SRAM_WAIT-1 to 0, giving SRAM_WAIT strobe cycles
                        cnt_d        = CNT_W'(SRAM_WAIT - 1);
                        state_d      = ST_SRAM_WR;
                    end
                end
            end
            ST_SRAM_WR: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hex_q        <= '0;
            led_q        <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hex_q        <= hex_d;
            led_q        <= led_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    // All handshake/strobe outputs decode straight from the state register,
    // so an asynchronous reset drops sram_we without waiting for an edge.
    assign req_ready  = (state_q == ST_IDLE);
    assign sram_we    = (state_q == ST_SRAM_WR);
    assign done       = (state_q == ST_DONE);
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign hex_out    = hex_q;
    assign led_out    = led_q;

endmodule

// File: tb/tb_mem_write_demux.sv
// Purpose : scoreboard bench for mem_write_demux; three instances with SRAM_WAIT = 2, 1, 15.
// Latency : expectations are queued at issue time and consumed when done pulses.
// Backpr. : the driver holds req_valid until it sees req_ready, bounded by a cycle budget.
module tb_mem_write_demux;

    localparam int N = 3;

    logic        Clk;
    logic        Reset_n;
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic [15:0] req_addr   [N];
    logic [15:0] req_data   [N];
    logic        done       [N];
    logic        sram_we    [N];
    logic [15:0] sram_addr  [N];
    logic [15:0] sram_wdata [N];
    logic [15:0] hex_out    [N];
    logic [15:0] led_out    [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        mem_write_demux #(.DATA_W(16), .SRAM_WAIT(W)) u_dut (
            .Clk        (Clk),
            .Reset_n    (Reset_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .req_data   (req_data[g]),
            .done       (done[g]),
            .sram_we    (sram_we[g]),
            .sram_addr  (sram_addr[g]),
            .sram_wdata (sram_wdata[g]),
            .hex_out    (hex_out[g]),
            .led_out    (led_out[g])
        );
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          k;
        logic [15:0] hex;
        logic [15:0] led;
        logic [15:0] sa;
        logic [15:0] sd;
        int          width;
        int          lat;
        int          gap;   // -1: accept spacing not checked
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int errors   = 0;
    int timeouts = 0;
    bit finish_req = 1'b0;

    // ---------------------------------------------------------------- monitor
    int cyc = 0;
    int acc_cyc   [N];
    int last_done [N];
    int gap_m     [N];
    int we_w      [N];
    bit busy      [N];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h (t=%0t)", name, k, act, req, $time);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            acc_cyc[k] = 0; last_done[k] = -1000; gap_m[k] = 0; we_w[k] = 0; busy[k] = 1'b0;
        end
    end

    always @(negedge Clk) begin
        exp_t e;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (!Reset_n) begin
                busy[k] = 1'b0;
                we_w[k] = 0;
                chk("rst_sram_we",  k, 32'(sram_we[k]),   32'd0);
                chk("rst_done",     k, 32'(done[k]),      32'd0);
                chk("rst_ready",    k, 32'(req_ready[k]), 32'd1);
                chk("rst_hex",      k, 32'(hex_out[k]),   32'd0);
                chk("rst_led",      k, 32'(led_out[k]),   32'd0);
                chk("rst_sram_adr", k, 32'(sram_addr[k]), 32'd0);
                chk("rst_sram_dat", k, 32'(sram_wdata[k]), 32'd0);
            end else begin
                chk("ready", k, 32'(req_ready[k]), busy[k] ? 32'd0 : 32'd1);
                if (sram_we[k]) begin
                    if (!busy[k]) begin
                        chk("sram_we_idle", k, 32'd1, 32'd0);
                    end else begin
                        we_w[k]++;
                        if (exp_q.size() > 0 && exp_q[0].k == k) begin
                            chk("strobe_addr", k, 32'(sram_addr[k]),  32'(exp_q[0].sa));
                            chk("strobe_data", k, 32'(sram_wdata[k]), 32'(exp_q[0].sd));
                        end
                    end
                end
                if (done[k]) begin
                    if (exp_q.size() == 0 || exp_q[0].k != k) begin
                        chk("unexpected_done", k, 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("hex_out",    k, 32'(hex_out[k]),    32'(e.hex));
                        chk("led_out",    k, 32'(led_out[k]),    32'(e.led));
                        chk("sram_addr",  k, 32'(sram_addr[k]),  32'(e.sa));
                        chk("sram_wdata", k, 32'(sram_wdata[k]), 32'(e.sd));
                        chk("we_width",   k, 32'(we_w[k]),       32'(e.width));
                        chk("latency",    k, 32'(cyc - acc_cyc[k]), 32'(e.lat));
                        if (e.gap >= 0) chk("accept_gap", k, 32'(gap_m[k]), 32'(e.gap));
                    end
                    busy[k]      = 1'b0;
                    last_done[k] = cyc;
                end
                if (req_valid[k] && req_ready[k]) begin
                    busy[k]    = 1'b1;
                    acc_cyc[k] = cyc;
                    gap_m[k]   = cyc - last_done[k];
                    we_w[k]    = 0;
                end
            end
        end
        if (finish_req) begin
            chk("timeouts", 0, 32'(timeouts), 32'd0);
            chk("pending",  0, 32'(exp_q.size()), 32'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic push(input int k, input logic [15:0] hex, input logic [15:0] led,
                        input logic [15:0] sa, input logic [15:0] sd,
                        input int width, input int lat, input int gap);
        exp_t e;
        e.k = k; e.hex = hex; e.led = led; e.sa = sa; e.sd = sd;
        e.width = width; e.lat = lat; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Presents a request and returns #1 after the accepting edge, leaving req_valid high.
    task automatic send(input int k, input logic [15:0] a, input logic [15:0] d);
        req_valid[k] = 1'b1;
        req_addr[k]  = a;
        req_data[k]  = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (req_ready[k]) begin
                @(posedge Clk);
                #1;
                return;
            end
        end
        timeouts++;
        $display("FAIL send_timeout[%0d]: addr %0h not accepted within 40 cycles", k, a);
    endtask

    // Idle bus carries a hex-register address so a spurious accept would be visible.
    task automatic idle(input int k);
        req_valid[k] = 1'b0;
        req_addr[k]  = 16'hFFFF;
        req_data[k]  = 16'hDEAD;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 60; i++) begin
            @(posedge Clk);
            if (exp_q.size() == 0) begin
                #1;
                return;
            end
        end
        timeouts++;
        $display("FAIL drain_timeout: %0d completions outstanding", exp_q.size());
    endtask

    initial begin
        Reset_n = 1'b0;
        for (int k = 0; k < N; k++) idle(k);
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(posedge Clk); #1;

        // hex write: done next cycle, no strobe, LED untouched
        push(0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 1, -1);
        send(0, 16'hFFFF, 16'h1234);
        idle(0);
        wait_empty();

        // SRAM write followed by an LED write held on the bus while busy
        push(0, 16'h1234, 16'h0000, 16'h3000, 16'hBEEF, 2, 3, -1);
        push(0, 16'h1234, 16'h00FF, 16'h3000, 16'hBEEF, 0, 1, 1);
        send(0, 16'h3000, 16'hBEEF);
        send(0, 16'hFFFE, 16'h00FF);
        idle(0);
        wait_empty();

        // reset during the second strobe cycle: write aborted, no done
        send(0, 16'h4000, 16'h5555);
        idle(0);
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        repeat (4) @(posedge Clk);
        #1;

        push(0, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 0, 1, -1);
        send(0, 16'hFFFE, 16'hBEEF);
        idle(0);
        wait_empty();

        // SRAM_WAIT = 1; address 0x0000 is an SRAM address
        push(1, 16'h0000, 16'h0000, 16'h0000, 16'hA5A5, 1, 2, -1);
        send(1, 16'h0000, 16'hA5A5);
        idle(1);
        wait_empty();
        push(1, 16'h0000, 16'h0F0F, 16'h0000, 16'hA5A5, 0, 1, -1);
        send(1, 16'hFFFE, 16'h0F0F);
        idle(1);
        wait_empty();

        // SRAM_WAIT = 15; 0xFFFD is one off the I/O window and must go to SRAM
        push(2, 16'h0000, 16'h0000, 16'h7FFE, 16'hC3C3, 15, 16, -1);
        send(2, 16'h7FFE, 16'hC3C3);
        idle(2);
        wait_empty();
        push(2, 16'h0001, 16'h0000, 16'h7FFE, 16'hC3C3, 0, 1, -1);
        send(2, 16'hFFFF, 16'h0001);
        idle(2);
        wait_empty();
        push(2, 16'h0001, 16'h0000, 16'hFFFD, 16'h1111, 15, 16, -1);
        send(2, 16'hFFFD, 16'h1111);
        idle(2);
        wait_empty();

        repeat (3) @(posedge Clk);
        finish_req = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
